// File: rtl/wb_pkg.sv
// Shared definitions for the writeback port arbiter slice.
//   XLEN, REG_AW, N_REQ_DEF : default datapath / address widths and requester count
//   REQ_ALU/REQ_LSU/REQ_MDU : requester slot indices on the arbiter
//   wb_req_t                : one writeback request (destination + result)
package wb_pkg;
  localparam int XLEN      = 32;
  localparam int REG_AW    = 5;
  localparam int N_REQ_DEF = 3;

  localparam int REQ_ALU = 0;
  localparam int REQ_LSU = 1;
  localparam int REQ_MDU = 2;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_req_t;
endpackage

// File: rtl/wb_rr_arbiter.sv
// Request vector -> one-hot grant plus encoded grant index.
// Build option: WB_ARB_RR_EN selects round-robin (search starts one past ptr);
// without it the lowest valid index wins and the ptr port does not exist.
// Ports:
//   reqVec : per-requester valid
//   ptr    : last granted index (round-robin build only)
//   grant  : one-hot grant, zero when no request
//   gIdx   : encoded grant index, 0 when no request
module wb_rr_arbiter #(
  parameter  int N_REQ = 3,
  localparam int IDXW  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] reqVec,
`ifdef WB_ARB_RR_EN
  input  logic [IDXW-1:0]  ptr,
`endif
  output logic [N_REQ-1:0] grant,
  output logic [IDXW-1:0]  gIdx
);
  import wb_pkg::*;

  logic found;

`ifdef WB_ARB_RR_EN
  // Walk ptr+1 .. ptr+N_REQ; the last granted requester is visited last.
  always_comb begin
    int idx;
    idx   = 0;
    grant = '0;
    gIdx  = '0;
    found = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (!found && reqVec[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        gIdx       = IDXW'(idx);
      end
    end
  end
`else
  always_comb begin
    grant = '0;
    gIdx  = '0;
    found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && reqVec[k]) begin
        found    = 1'b1;
        grant[k] = 1'b1;
        gIdx     = IDXW'(k);
      end
    end
  end
`endif
endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register file's single write port between N_REQ writeback sources
// and tracks destinations with outstanding writebacks for ID hazard checks.
// Build option: WB_ARB_RR_EN = round-robin arbitration, otherwise fixed priority.
// Ports:
//   clk, reset            : clock, asynchronous active-high reset
//   req_valid/req_ready   : per-requester handshake, ready is one-hot or zero
//   req_rd/req_data       : flattened per-requester destination / result
//   issue_valid/issue_rd  : ID issued an instruction writing issue_rd
//   rf_we/rf_waddr/rf_wdata : registered register-file write port
//   busy                  : bit r set while a write to x r is outstanding
module wb_port_arbiter #(
  parameter  int N_REQ  = wb_pkg::N_REQ_DEF,
  parameter  int XLEN   = wb_pkg::XLEN,
  parameter  int REG_AW = wb_pkg::REG_AW,
  localparam int IDXW   = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ*REG_AW-1:0] req_rd,
  input  logic [N_REQ*XLEN-1:0]   req_data,
  input  logic                    issue_valid,
  input  logic [REG_AW-1:0]       issue_rd,
  output logic                    rf_we,
  output logic [REG_AW-1:0]       rf_waddr,
  output logic [XLEN-1:0]         rf_wdata,
  output logic [31:0]             busy
);
  import wb_pkg::*;

  logic [N_REQ-1:0]             grant;
  logic [IDXW-1:0]              gIdx;
  logic                         accept;
  logic [N_REQ-1:0][REG_AW-1:0] rdArr;
  logic [N_REQ-1:0][XLEN-1:0]   dataArr;
  logic [REG_AW-1:0]            selRd;
  logic [XLEN-1:0]              selData;
  logic [31:0]                  busyNxt;

  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign rdArr[i]   = req_rd[i*REG_AW +: REG_AW];
    assign dataArr[i] = req_data[i*XLEN +: XLEN];
  end

`ifdef WB_ARB_RR_EN
  logic [IDXW-1:0] ptr;

  wb_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .reqVec (req_valid),
    .ptr    (ptr),
    .grant  (grant),
    .gIdx   (gIdx)
  );

  // ptr resets to the top index so requester 0 is searched first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       ptr <= IDXW'(N_REQ - 1);
    else if (accept) ptr <= gIdx;
  end
`else
  wb_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .reqVec (req_valid),
    .grant  (grant),
    .gIdx   (gIdx)
  );
`endif

  // Grant already implies valid, so any grant bit is an acceptance.
  assign req_ready = reset ? '0 : grant;
  assign accept    = |grant;
  assign selRd     = rdArr[gIdx];
  assign selData   = dataArr[gIdx];

  // Clear the retiring destination first so a same-cycle reissue keeps it busy.
  always_comb begin
    busyNxt = busy;
    if (accept) busyNxt[selRd] = 1'b0;
    if (issue_valid && (issue_rd != '0)) busyNxt[issue_rd] = 1'b1;
    busyNxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      busy     <= '0;
    end else begin
      // rd==0 still consumes the slot but never writes.
      rf_we <= accept && (selRd != '0);
      if (accept) begin
        rf_waddr <= selRd;
        rf_wdata <= selData;
      end
      busy <= busyNxt;
    end
  end
endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;
  import wb_pkg::*;

  localparam int NR = N_REQ_DEF;

  typedef struct {
    logic    we;
    wb_req_t w;
  } wr_t;

  logic              clk = 1'b0;
  logic              reset;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [NR*REG_AW-1:0] req_rd;
  logic [NR*XLEN-1:0]   req_data;
  logic              issue_valid;
  logic [REG_AW-1:0] issue_rd;
  logic              rf_we;
  logic [REG_AW-1:0] rf_waddr;
  logic [XLEN-1:0]   rf_wdata;
  logic [31:0]       busy;

  int errors = 0;
  int checks = 0;
  wr_t sb[$];

  wb_port_arbiter #(.N_REQ(NR), .XLEN(XLEN), .REG_AW(REG_AW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_rd(req_rd), .req_data(req_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setReq(input int i, input logic v, input logic [REG_AW-1:0] rd,
                        input logic [XLEN-1:0] d);
    req_valid[i] = v;
    req_rd[i*REG_AW +: REG_AW] = rd;
    req_data[i*XLEN +: XLEN] = d;
  endtask

  // Push the write the bench expects from requester i being accepted this cycle.
  task automatic expectAccept(input string tag, input int i);
    wr_t e;
    logic [NR-1:0] oh;
    oh = '0;
    oh[i] = 1'b1;
    #2;
    chk({tag, "_ready"}, 64'(req_ready), 64'(oh));
    e.w.rd   = req_rd[i*REG_AW +: REG_AW];
    e.w.data = req_data[i*XLEN +: XLEN];
    e.we     = (e.w.rd != '0);
    sb.push_back(e);
  endtask

  task automatic checkWrite(input string tag);
    wr_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s scoreboard empty observed=nothing expected=entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_we"}, 64'(rf_we), 64'(e.we));
      chk({tag, "_waddr"}, 64'(rf_waddr), 64'(e.w.rd));
      chk({tag, "_wdata"}, 64'(rf_wdata), 64'(e.w.data));
    end
  endtask

  initial begin
    int expIdx;
    reset = 1'b1;
    req_valid = '0; req_rd = '0; req_data = '0;
    issue_valid = 1'b0; issue_rd = '0;
    for (int i = 0; i < NR; i++) setReq(i, 1'b1, REG_AW'(i + 1), 32'hA000_0000 + XLEN'(i));

    // Reset holds everything quiet even with all requesters valid.
    tick(); tick();
    chk("rst_ready", 64'(req_ready), 64'(0));
    chk("rst_we", 64'(rf_we), 64'(0));
    chk("rst_waddr", 64'(rf_waddr), 64'(0));
    chk("rst_wdata", 64'(rf_wdata), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));

    // All valid continuously: RR 0,1,2,0,1,2 ; fixed 0,0,0,...
    reset = 1'b0;
    for (int n = 0; n < 6; n++) begin
`ifdef WB_ARB_RR_EN
      expIdx = n % NR;
`else
      expIdx = 0;
`endif
      expectAccept($sformatf("seq%0d", n), expIdx);
      tick();
      checkWrite($sformatf("seq%0d", n));
      #1;
    end
    chk("seq_busy", 64'(busy), 64'(0));

    // Idle cycle: no grant, write enable drops, address/data hold.
    for (int i = 0; i < NR; i++) req_valid[i] = 1'b0;
    #2;
    chk("idle_ready", 64'(req_ready), 64'(0));
    tick();
    chk("idle_we", 64'(rf_we), 64'(0));

    // Only LSU valid.
    setReq(REQ_LSU, 1'b1, 5'd5, 32'hDEADBEEF);
    expectAccept("lsu", REQ_LSU);
    tick();
    checkWrite("lsu");
    req_valid = '0;

    // ALU to x0: accepted, no write, busy untouched.
    setReq(REQ_ALU, 1'b1, 5'd0, 32'h1234);
    expectAccept("alu_x0", REQ_ALU);
    tick();
    checkWrite("alu_x0");
    chk("alu_x0_busy", 64'(busy), 64'(0));
    req_valid = '0;

    // Issue to x0 never marks busy.
    issue_valid = 1'b1; issue_rd = 5'd0;
    tick();
    chk("iss_x0_busy", 64'(busy), 64'(0));

    // Issue x7, then accept x7 while re-issuing x7 (set wins), then accept alone.
    issue_rd = 5'd7;
    tick();
    chk("iss7_busy", 64'(busy), 64'(32'h80));
    setReq(REQ_MDU, 1'b1, 5'd7, 32'h0000_0777);
    expectAccept("mdu7a", REQ_MDU);
    tick();
    checkWrite("mdu7a");
    chk("mdu7a_busy", 64'(busy), 64'(32'h80));
    issue_valid = 1'b0;
    setReq(REQ_MDU, 1'b1, 5'd7, 32'h0000_0778);
    expectAccept("mdu7b", REQ_MDU);
    tick();
    checkWrite("mdu7b");
    chk("mdu7b_busy", 64'(busy), 64'(0));

    // Set up rf_we=1 and busy[3]=1, then reset mid-cycle.
    issue_valid = 1'b1; issue_rd = 5'd3;
    setReq(REQ_MDU, 1'b1, 5'd9, 32'h0000_0999);
    expectAccept("pre_rst", REQ_MDU);
    tick();
    checkWrite("pre_rst");
    chk("pre_rst_busy", 64'(busy), 64'(32'h8));
    issue_valid = 1'b0;
    #1;
    reset = 1'b1;
    #1;
    chk("arst_we", 64'(rf_we), 64'(0));
    chk("arst_busy", 64'(busy), 64'(0));
    chk("arst_ready", 64'(req_ready), 64'(0));
    tick();
    reset = 1'b0;

    // After reset requester 0 has top priority in either mode.
    for (int i = 0; i < NR; i++) setReq(i, 1'b1, REG_AW'(i + 10), 32'hB000_0000 + XLEN'(i));
    expectAccept("post_rst", 0);
    tick();
    checkWrite("post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
